// File: rtl/intc_pkg.sv
// Shared types and constants for the multichannel interrupt controller.
package intc_pkg;

  // Arbiter states: IDLE offers nothing, OFFER drives irq with a held irq_id.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;

  // Arbitration mode selectors for the ARB_MODE parameter.
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Width of a per-channel pending counter able to hold 0..depth.
  function automatic int pend_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/intc_pend_counter.sv
// Saturating per-channel pending-request counter with sticky overflow flag.
module intc_pend_counter
  import intc_pkg::*;
#(
  parameter int PEND_DEPTH = 32,
  parameter int CW         = pend_cnt_width(PEND_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          reti,
  input  logic          ovf_clr,
  output logic [CW-1:0] pend_cnt,
  output logic          ovf
);

  localparam logic [CW-1:0] DEPTH_C = CW'(PEND_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  // Next count/overflow: a dropped request sets ovf after the clear so set wins.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    case ({req, reti})
      2'b10: begin
        if (cnt_q < DEPTH_C) begin
          cnt_d = cnt_q + ONE_C;
        end else begin
          ovf_d = 1'b1;
        end
      end
      2'b01: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE_C;
        end
      end
      2'b11: begin
        if (cnt_q == '0) begin
          cnt_d = ONE_C;
        end
      end
      default: begin
      end
    endcase
  end

  // Count and overflow registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign pend_cnt = cnt_q;
  assign ovf      = ovf_q;

endmodule

// File: rtl/intc_multichannel.sv
// Multichannel interrupt controller: per-channel pending counters feeding a
// two-state arbiter that offers one channel at a time and tracks in-service.
module intc_multichannel
  import intc_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int PEND_DEPTH = 32,
  parameter int ARB_MODE   = ARB_FIXED
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         int_req,
  input  logic [NUM_CH-1:0]         int_en,
  input  logic [NUM_CH-1:0]         reti,
  input  logic                      irq_ack,
  input  logic [NUM_CH-1:0]         ovf_clr,
  output logic [NUM_CH-1:0]         int_flag,
  output logic                      irq,
  output logic [$clog2(NUM_CH)-1:0] irq_id,
  output logic [NUM_CH-1:0]         in_service,
  output logic [NUM_CH-1:0]         ovf
);

  localparam int IDW = $clog2(NUM_CH);
  localparam int CW  = pend_cnt_width(PEND_DEPTH);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_CH - 1);
  localparam logic [IDW-1:0] ONE_ID  = IDW'(1);

  logic [CW-1:0]     pend_cnt [NUM_CH];
  logic [NUM_CH-1:0] eligible;

  arb_state_e        state_q, state_d;
  logic [IDW-1:0]    irq_id_q, irq_id_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0] in_service_q, in_service_d;

  logic [IDW-1:0]    start_ptr;
  logic [IDW-1:0]    win_id;
  logic              win_found;
  int                cand;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    intc_pend_counter #(
      .PEND_DEPTH(PEND_DEPTH),
      .CW        (CW)
    ) u_pend (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (int_req[g]),
      .reti    (reti[g]),
      .ovf_clr (ovf_clr[g]),
      .pend_cnt(pend_cnt[g]),
      .ovf     (ovf[g])
    );
  end

  // Flags follow the registered counts; enable only masks, never alters counts.
  always_comb begin
    int_flag = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      int_flag[i] = int_en[i] & (pend_cnt[i] != '0);
    end
    eligible = int_flag & ~in_service_q;
  end

  // Winner search from start_ptr with wrap; fixed mode always starts at 0.
  always_comb begin
    start_ptr = (ARB_MODE == ARB_RR) ? rr_ptr_q : '0;
    win_found = 1'b0;
    win_id    = '0;
    cand      = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = (int'(start_ptr) + k) % NUM_CH;
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_id    = IDW'(cand);
      end
    end
  end

  // Arbiter next state; an ack in the same cycle as a reti re-marks service.
  always_comb begin
    state_d      = state_q;
    irq_id_d     = irq_id_q;
    rr_ptr_d     = rr_ptr_q;
    in_service_d = in_service_q & ~reti;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d  = OFFER;
          irq_id_d = win_id;
        end
      end
      OFFER: begin
        if (irq_ack) begin
          in_service_d[irq_id_q] = 1'b1;
          state_d                = IDLE;
          rr_ptr_d               = (irq_id_q == LAST_ID) ? '0 : irq_id_q + ONE_ID;
        end else if (!eligible[irq_id_q]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Arbiter registers, cleared asynchronously so no offer survives reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      irq_id_q     <= '0;
      rr_ptr_q     <= '0;
      in_service_q <= '0;
    end else begin
      state_q      <= state_d;
      irq_id_q     <= irq_id_d;
      rr_ptr_q     <= rr_ptr_d;
      in_service_q <= in_service_d;
    end
  end

  assign irq        = (state_q == OFFER);
  assign irq_id     = irq_id_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_intc_multichannel.sv
// Scoreboard bench: a fixed-priority and a round-robin instance share stimulus;
// a behavioural model predicts each cycle's outputs into a queue that a
// separate monitor pops and compares.
module tb_intc_multichannel;

  localparam int NCH   = 3;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] int_req = '0;
  logic [NCH-1:0] int_en = '0;
  logic [NCH-1:0] reti = '0;
  logic           irq_ack = 1'b0;
  logic [NCH-1:0] ovf_clr = '0;

  logic [NCH-1:0] flag_fx, insvc_fx, ovf_fx, flag_rr, insvc_rr, ovf_rr;
  logic           irq_fx, irq_rr;
  logic [1:0]     id_fx, id_rr;

  typedef struct packed {
    logic [NCH-1:0] flag;
    logic           irq;
    logic [1:0]     id;
    logic [NCH-1:0] insvc;
    logic [NCH-1:0] ovf;
  } exp_t;

  typedef struct packed {
    exp_t fx;
    exp_t rr;
  } pair_t;

  pair_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Model state: counts/overflow are shared, arbiter view is per mode (0 fx, 1 rr).
  int  m_cnt[NCH];
  bit  m_ovf[NCH];
  bit  m_offer[2];
  int  m_id[2];
  int  m_rr[2];
  bit  m_svc[2][NCH];
  logic [NCH-1:0] cur_en = '0;

  always #5 clk = ~clk;

  intc_multichannel #(.NUM_CH(NCH), .PEND_DEPTH(DEPTH), .ARB_MODE(0)) dut_fx (
    .clk(clk), .rst_n(rst_n), .int_req(int_req), .int_en(int_en), .reti(reti),
    .irq_ack(irq_ack), .ovf_clr(ovf_clr), .int_flag(flag_fx), .irq(irq_fx),
    .irq_id(id_fx), .in_service(insvc_fx), .ovf(ovf_fx)
  );

  intc_multichannel #(.NUM_CH(NCH), .PEND_DEPTH(DEPTH), .ARB_MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .int_req(int_req), .int_en(int_en), .reti(reti),
    .irq_ack(irq_ack), .ovf_clr(ovf_clr), .int_flag(flag_rr), .irq(irq_rr),
    .irq_id(id_rr), .in_service(insvc_rr), .ovf(ovf_rr)
  );

  function automatic void checkOutput(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = 0;
      m_ovf[i] = 0;
      m_svc[0][i] = 0;
      m_svc[1][i] = 0;
    end
    for (int m = 0; m < 2; m++) begin
      m_offer[m] = 0;
      m_id[m]    = 0;
      m_rr[m]    = 0;
    end
  endfunction

  // One clock of the reference behaviour, evaluated on pre-edge state.
  function automatic void model_step(input logic [NCH-1:0] req, en, rt, clr, input logic ack);
    for (int m = 0; m < 2; m++) begin
      bit el[NCH];
      int start;
      for (int i = 0; i < NCH; i++) el[i] = en[i] && (m_cnt[i] > 0) && !m_svc[m][i];
      for (int i = 0; i < NCH; i++) if (rt[i]) m_svc[m][i] = 0;
      if (!m_offer[m]) begin
        start = (m == 1) ? m_rr[m] : 0;
        for (int k = 0; k < NCH; k++) begin
          int c;
          c = (start + k) % NCH;
          if (!m_offer[m] && el[c]) begin
            m_offer[m] = 1;
            m_id[m]    = c;
          end
        end
      end else if (ack) begin
        m_svc[m][m_id[m]] = 1;
        m_offer[m] = 0;
        m_rr[m]    = (m_id[m] + 1) % NCH;
      end else if (!el[m_id[m]]) begin
        m_offer[m] = 0;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (clr[i]) m_ovf[i] = 0;
      if (req[i] && rt[i]) begin
        if (m_cnt[i] == 0) m_cnt[i] = 1;
      end else if (req[i]) begin
        if (m_cnt[i] < DEPTH) m_cnt[i] = m_cnt[i] + 1;
        else m_ovf[i] = 1;
      end else if (rt[i] && m_cnt[i] > 0) begin
        m_cnt[i] = m_cnt[i] - 1;
      end
    end
  endfunction

  function automatic exp_t build_exp(input int m, input logic [NCH-1:0] en);
    exp_t e;
    e.irq = m_offer[m];
    e.id  = 2'(m_id[m]);
    for (int i = 0; i < NCH; i++) begin
      e.flag[i]  = en[i] && (m_cnt[i] > 0);
      e.insvc[i] = m_svc[m][i];
      e.ovf[i]   = m_ovf[i];
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic [NCH-1:0] req, en, rt, input logic ack,
                               input logic [NCH-1:0] clr);
    pair_t p;
    @(negedge clk);
    int_req = req;
    int_en  = en;
    reti    = rt;
    irq_ack = ack;
    ovf_clr = clr;
    model_step(req, en, rt, clr, ack);
    p.fx = build_exp(0, en);
    p.rr = build_exp(1, en);
    exp_q.push_back(p);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, cur_en, '0, 1'b0, '0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".fx_out"}, int'({flag_fx, irq_fx, id_fx, insvc_fx, ovf_fx}), 0);
    checkOutput({tag, ".rr_out"}, int'({flag_rr, irq_rr, id_rr, insvc_rr, ovf_rr}), 0);
  endtask

  task automatic hardReset();
    settle();
    rst_n   = 1'b0;
    int_req = '0;
    reti    = '0;
    irq_ack = 1'b0;
    ovf_clr = '0;
    model_reset();
    #1;
    checkAllZero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Wait a bounded number of cycles for the chosen instance to raise irq.
  task automatic waitIrq(input bit use_rr, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 10 && !ok; n++) begin
      idle(1);
      settle();
      ok = use_rr ? irq_rr : irq_fx;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_irq timeout rr=%0d actual=0 expected=1", use_rr);
    end
  endtask

  // Monitor: pop one prediction per cycle and compare both instances.
  initial begin
    pair_t p;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        p = exp_q.pop_front();
        checkOutput("fx.int_flag", int'(flag_fx), int'(p.fx.flag));
        checkOutput("fx.irq", int'(irq_fx), int'(p.fx.irq));
        if (p.fx.irq) checkOutput("fx.irq_id", int'(id_fx), int'(p.fx.id));
        checkOutput("fx.in_service", int'(insvc_fx), int'(p.fx.insvc));
        checkOutput("fx.ovf", int'(ovf_fx), int'(p.fx.ovf));
        checkOutput("rr.int_flag", int'(flag_rr), int'(p.rr.flag));
        checkOutput("rr.irq", int'(irq_rr), int'(p.rr.irq));
        if (p.rr.irq) checkOutput("rr.irq_id", int'(id_rr), int'(p.rr.id));
        checkOutput("rr.in_service", int'(insvc_rr), int'(p.rr.insvc));
        checkOutput("rr.ovf", int'(ovf_rr), int'(p.rr.ovf));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ok;
    int seq[4];
    logic [31:0] r;
    seq = '{0, 1, 2, 0};
    model_reset();

    // Power-on reset and overflow / drain of channel 0.
    hardReset();
    cur_en = 3'b111;
    for (int i = 0; i < 5; i++) applyStimulus(3'b001, cur_en, '0, 1'b0, '0);
    settle();
    checkOutput("ovf0_after_5_req", int'(ovf_fx[0]), 1);
    for (int i = 0; i < 3; i++) applyStimulus('0, cur_en, 3'b001, 1'b0, '0);
    settle();
    checkOutput("flag0_after_3_reti", int'(flag_fx[0]), 1);
    applyStimulus('0, cur_en, 3'b001, 1'b0, '0);
    settle();
    checkOutput("flag0_after_4_reti", int'(flag_fx[0]), 0);
    applyStimulus('0, cur_en, '0, 1'b0, 3'b001);
    settle();
    checkOutput("ovf0_after_clr", int'(ovf_fx[0]), 0);

    // Simultaneous request and return on channel 1 at count 2 and at count 0.
    applyStimulus(3'b010, cur_en, '0, 1'b0, '0);
    applyStimulus(3'b010, cur_en, '0, 1'b0, '0);
    applyStimulus(3'b010, cur_en, 3'b010, 1'b0, '0);
    applyStimulus('0, cur_en, 3'b010, 1'b0, '0);
    settle();
    checkOutput("flag1_count_stayed_2", int'(flag_fx[1]), 1);
    applyStimulus('0, cur_en, 3'b010, 1'b0, '0);
    settle();
    checkOutput("flag1_drained", int'(flag_fx[1]), 0);
    applyStimulus(3'b010, cur_en, 3'b010, 1'b0, '0);
    settle();
    checkOutput("flag1_req_reti_at_0", int'(flag_fx[1]), 1);
    applyStimulus('0, cur_en, 3'b010, 1'b0, '0);
    idle(2);

    // Fixed priority: ch0 wins over ch2, then ch2 after ack and return.
    hardReset();
    applyStimulus(3'b101, 3'b000, '0, 1'b0, '0);
    cur_en = 3'b111;
    waitIrq(1'b0, ok);
    if (ok) checkOutput("fx_first_id", int'(id_fx), 0);
    applyStimulus('0, cur_en, '0, 1'b1, '0);
    applyStimulus('0, cur_en, 3'b001, 1'b0, '0);
    waitIrq(1'b0, ok);
    if (ok) checkOutput("fx_second_id", int'(id_fx), 2);
    idle(2);

    // Round robin: ids 0,1,2,0 with ch0 holding two requests.
    hardReset();
    applyStimulus(3'b111, 3'b000, '0, 1'b0, '0);
    applyStimulus(3'b001, 3'b000, '0, 1'b0, '0);
    cur_en = 3'b111;
    for (int j = 0; j < 4; j++) begin
      waitIrq(1'b1, ok);
      if (ok) checkOutput("rr_seq_id", int'(id_rr), seq[j]);
      applyStimulus('0, cur_en, '0, 1'b1, '0);
      applyStimulus('0, cur_en, 3'(1 << seq[j]), 1'b0, '0);
    end
    idle(2);

    // Masking the offered channel withdraws the offer; re-enable re-offers it.
    hardReset();
    cur_en = 3'b111;
    applyStimulus(3'b010, cur_en, '0, 1'b0, '0);
    waitIrq(1'b0, ok);
    if (ok) checkOutput("mask_first_id", int'(id_fx), 1);
    cur_en = 3'b101;
    idle(1);
    settle();
    checkOutput("mask_irq_dropped", int'(irq_fx), 0);
    cur_en = 3'b111;
    waitIrq(1'b0, ok);
    if (ok) checkOutput("mask_reoffer_id", int'(id_fx), 1);

    // Reset mid-offer with counts 3/2/1 clears everything immediately.
    hardReset();
    applyStimulus(3'b111, cur_en, '0, 1'b0, '0);
    applyStimulus(3'b011, cur_en, '0, 1'b0, '0);
    applyStimulus(3'b001, cur_en, '0, 1'b0, '0);
    waitIrq(1'b0, ok);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    checkAllZero("midoffer_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    settle();
    checkOutput("post_reset_irq_fx", int'(irq_fx), 0);
    checkOutput("post_reset_irq_rr", int'(irq_rr), 0);

    // Randomized traffic against the reference model.
    hardReset();
    for (int c = 0; c < 600; c++) begin
      r = $urandom;
      if (r[27:25] == 3'd0) cur_en = 3'($urandom_range(0, 7));
      applyStimulus(r[2:0] & r[5:3], cur_en, r[8:6] & r[11:9] & r[14:12], r[15],
                    r[18:16] & r[21:19] & r[24:22]);
    end
    settle();
    repeat (2) @(posedge clk);
    #2;
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
